// File: rtl/set_assoc_cache_if.sv
// CPU and memory bus bundle for set_assoc_cache.
// The slave modport is the cache's view. The master modport is the environment's view:
// it drives the CPU requests and the memory responses.
interface set_assoc_cache_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic                  hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_rvalid, mem_ack,
    output cpu_rdata, cpu_ready, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_rvalid, mem_ack,
    input  cpu_rdata, cpu_ready, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate byte cache with per-set LRU.
// Read misses refill a whole line as a burst. Writes always go through to memory.
// Optional feature: define CACHE_STATS_EN to add the saturating stat_hits and stat_misses counters.
module set_assoc_cache #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic clock,
  input  logic reset,
`ifdef CACHE_STATS_EN
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
`endif
  set_assoc_cache_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, WRITE_MEM} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic                  hit_q, hit_d;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAY_W-1:0]      age_q [SETS][WAYS];
  logic [WAY_W-1:0]      age_d [SETS][WAYS];

  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]      tag_mem  [WAYS][SETS];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [OFF_W-1:0]      req_off;
  logic                  hit_any, found_free;
  logic [WAY_W-1:0]      hit_way, victim_way, data_way, touch_way;
  logic [OFF_W-1:0]      data_off;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_we, tag_we, touch;

  assign req_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_off = addr_q[OFF_W-1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that skips an assignment would infer a latch.
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: the lowest-numbered invalid way, otherwise the oldest way.
  always_comb begin
    found_free = 1'b0;
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !valid_q[req_idx][w]) begin
        victim_way = WAY_W'(w);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
  end

  // Controller next state, array write enables, LRU update and bus outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    victim_d   = victim_q;
    hit_d      = hit_q;
    valid_d    = valid_q;
    age_d      = age_q;
    data_we    = 1'b0;
    data_way   = hit_way;
    data_off   = req_off;
    data_wdata = wdata_q;
    tag_we     = 1'b0;
    touch      = 1'b0;
    touch_way  = hit_way;
    bus.cpu_rdata = '0;
    bus.cpu_ready = 1'b0;
    bus.hit       = hit_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d   = hit_any;
        bus.hit = hit_any;
        if (we_q) begin
          if (hit_any) begin
            data_we = 1'b1;
            touch   = 1'b1;
          end
          state_d = WRITE_MEM;
        end else if (hit_any) begin
          bus.cpu_rdata = data_mem[hit_way][req_idx][req_off];
          bus.cpu_ready = 1'b1;
          touch         = 1'b1;
          state_d       = IDLE;
        end else begin
          victim_d                     = victim_way;
          valid_d[req_idx][victim_way] = 1'b0;
          state_d                      = REFILL;
        end
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (bus.mem_rvalid) begin
          data_we    = 1'b1;
          data_way   = victim_q;
          data_off   = cnt_q;
          data_wdata = bus.mem_rdata;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) state_d = RESPOND;
        end
      end
      RESPOND: begin
        bus.cpu_ready = 1'b1;
        state_d       = IDLE;
        if (!we_q) begin
          bus.cpu_rdata              = data_mem[victim_q][req_idx][req_off];
          valid_d[req_idx][victim_q] = 1'b1;
          tag_we                     = 1'b1;
          touch                      = 1'b1;
          touch_way                  = victim_q;
        end
      end
      WRITE_MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (bus.mem_ack) state_d = RESPOND;
      end
      default: state_d = IDLE;
    endcase
    if (touch && (WAYS > 1)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way) begin
          age_d[req_idx][w] = '0;
        end else if (age_q[req_idx][w] < age_q[req_idx][touch_way]) begin
          age_d[req_idx][w] = age_q[req_idx][w] + 1'b1;
        end
      end
    end
  end

  // Control state, valid bits and LRU ages, with a synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignment so that every flop samples the values from before the edge.
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
      hit_q    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      hit_q    <= hit_d;
      valid_q  <= valid_d;
      age_q    <= age_d;
    end
  end

  // Line data and tag storage.
  always_ff @(posedge clock) begin
    // NOTE: data and tags are left unreset; the valid bits alone decide whether their contents are used.
    if (data_we) data_mem[data_way][req_idx][data_off] <= data_wdata;
    if (tag_we)  tag_mem[victim_q][req_idx] <= req_tag;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hits_q, hits_d, misses_q, misses_d;

  // Saturating hit and miss counters, updated once per lookup.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == LOOKUP) begin
      if (hit_any && (hits_q != 16'hFFFF)) hits_d = hits_q + 16'd1;
      if (!hit_any && (misses_q != 16'hFFFF)) misses_d = misses_q + 16'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache. A memory responder model serves the bus.
// Expected CPU responses and memory transactions are queued as requests are issued.
// Two monitor processes pop those queues and compare against the DUT.
module tb_set_assoc_cache;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  set_assoc_cache_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  set_assoc_cache dut (
    .clock      (clock),
    .reset      (reset),
`ifdef CACHE_STATS_EN
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
`endif
    .bus        (bus)
  );

  typedef struct {
    bit         is_read;
    logic [7:0] rdata;
    logic       hit;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  cpu_exp_t   cpu_q[$];
  mem_exp_t   mem_q[$];
  logic [7:0] mem_model [0:65535];
  int n_checks = 0;
  int n_fail   = 0;
  int beat     = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  int max_beats = 4;
  bit gap_en   = 1'b0;
  bit gap_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: refill beats from the model, and write acks after ack_delay wait cycles.
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clock);
      bus.mem_rvalid = 1'b0;
      bus.mem_ack    = 1'b0;
      if (!bus.mem_req) begin
        beat     = 0;
        wait_cnt = 0;
        gap_done = 1'b0;
      end else if (!bus.mem_we) begin
        if (gap_en && (beat == 2) && !gap_done) begin
          gap_done = 1'b1;
        end else if (beat < max_beats) begin
          bus.mem_rdata  = mem_model[{bus.mem_addr[15:2], 2'(beat)}];
          bus.mem_rvalid = 1'b1;
          beat++;
        end
      end else begin
        if (wait_cnt == ack_delay) begin
          bus.mem_ack = 1'b1;
          mem_model[bus.mem_addr] = bus.mem_wdata;
        end
        wait_cnt++;
      end
    end
  end

  // CPU response monitor: one expected entry per cpu_ready cycle.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clock);
      if (bus.cpu_ready) begin
        if (cpu_q.size() == 0) begin
          check("unexpected_cpu_ready", bus.cpu_ready, 1'b0);
        end else begin
          e = cpu_q.pop_front();
          check("hit", bus.hit, e.hit);
          if (e.is_read) check("cpu_rdata", bus.cpu_rdata, e.rdata);
        end
      end
    end
  end

  // Memory request monitor: each new mem_req is compared against the next expected transaction.
  initial begin
    mem_exp_t m;
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.mem_req && !prev) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", bus.mem_req, 1'b0);
        end else begin
          m = mem_q.pop_front();
          check("mem_we", bus.mem_we, m.we);
          check("mem_addr", bus.mem_addr, m.addr);
          if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end
      prev = bus.mem_req;
    end
  end

  task automatic push_expect(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rdata, input logic exp_hit, input bit with_cpu);
    cpu_exp_t e;
    mem_exp_t m;
    if (with_cpu) begin
      e.is_read = !we;
      e.rdata   = exp_rdata;
      e.hit     = exp_hit;
      cpu_q.push_back(e);
    end
    if (we || !exp_hit) begin
      m.we    = we;
      m.addr  = we ? addr : {addr[15:2], 2'b00};
      m.wdata = wdata;
      mem_q.push_back(m);
    end
  endtask

  // One CPU access; exp_lat > 0 also checks the cycle count from acceptance to cpu_ready.
  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rdata, input logic exp_hit, input int exp_lat);
    int lat;
    bit got;
    push_expect(we, addr, wdata, exp_rdata, exp_hit, 1'b1);
    @(negedge clock);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    lat = 0;
    got = 1'b0;
    while (!got && (lat < 100)) begin
      @(negedge clock);
      bus.cpu_req = 1'b0;
      lat++;
      if (bus.cpu_ready) got = 1'b1;
    end
    if (!got) check("ready_timeout", bus.cpu_ready, 1'b1);
    else if (exp_lat > 0) check("ready_latency", lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int polls;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int a = 0; a < 65536; a++) mem_model[a] = 8'h00;
    mem_model[16'h0040] = 8'hAA; mem_model[16'h0041] = 8'hBB;
    mem_model[16'h0042] = 8'hCC; mem_model[16'h0043] = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      mem_model[16'h0000 + i] = 8'h10 + 8'(i);
      mem_model[16'h0080 + i] = 8'h20 + 8'(i);
      mem_model[16'h0100 + i] = 8'h30 + 8'(i);
      mem_model[16'h2000 + i] = 8'h40 + 8'(i);
      mem_model[16'h0204 + i] = 8'h50 + 8'(i);
    end

    // Reset held for two cycles: every output is zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check("rst_hit", bus.hit, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    reset = 1'b1;

    // Read miss refills line 0x0040 with AA..DD, then a hit on the same line.
    cpu_access(1'b0, 16'h0042, 8'h00, 8'hCC, 1'b0, 0);
    cpu_access(1'b0, 16'h0043, 8'h00, 8'hDD, 1'b1, 1);
`ifdef CACHE_STATS_EN
    check("stat_hits", stat_hits, 16'd1);
    check("stat_misses", stat_misses, 16'd1);
`endif

    // Write hit goes through to memory with a 3-cycle ack, and the cached copy is updated.
    ack_delay = 3;
    cpu_access(1'b1, 16'h0041, 8'h5A, 8'h00, 1'b1, 0);
    cpu_access(1'b0, 16'h0041, 8'h00, 8'h5A, 1'b1, 1);

    // LRU in set 0: 0x0080 is evicted after 0x0000 is touched. The 0x0080 refill has a beat gap.
    cpu_access(1'b0, 16'h0000, 8'h00, 8'h10, 1'b0, 0);
    gap_en = 1'b1;
    cpu_access(1'b0, 16'h0080, 8'h00, 8'h20, 1'b0, 0);
    gap_en = 1'b0;
    cpu_access(1'b0, 16'h0000, 8'h00, 8'h10, 1'b1, 1);
    cpu_access(1'b0, 16'h0100, 8'h00, 8'h30, 1'b0, 0);
    cpu_access(1'b0, 16'h0000, 8'h00, 8'h10, 1'b1, 1);
    cpu_access(1'b0, 16'h0080, 8'h00, 8'h20, 1'b0, 0);
    // Back-to-back misses in one set: the freshly refilled line is MRU, so 0x0000 is evicted.
    cpu_access(1'b0, 16'h0100, 8'h00, 8'h30, 1'b0, 0);
    cpu_access(1'b0, 16'h0080, 8'h00, 8'h20, 1'b1, 1);
    cpu_access(1'b0, 16'h0001, 8'h00, 8'h11, 1'b0, 0);

    // Write miss: memory write only, no allocation, so the following read misses.
    ack_delay = 0;
    cpu_access(1'b1, 16'h2000, 8'h77, 8'h00, 1'b0, 0);
    cpu_access(1'b0, 16'h2000, 8'h00, 8'h77, 1'b0, 0);
    cpu_access(1'b0, 16'h2001, 8'h00, 8'h41, 1'b1, 1);

    // Reset after two refill beats aborts the refill; a re-read refills the whole line.
    max_beats = 2;
    push_expect(1'b0, 16'h0206, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0206;
    @(negedge clock);
    bus.cpu_req = 1'b0;
    polls = 0;
    while ((beat < 2) && (polls < 50)) begin
      @(negedge clock);
      polls++;
    end
    check("abort_beats_seen", (beat >= 2), 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_mem_req", bus.mem_req, 1'b0);
    check("abort_cpu_ready", bus.cpu_ready, 1'b0);
    check("abort_hit", bus.hit, 1'b0);
    reset = 1'b1;
    max_beats = 4;
    cpu_access(1'b0, 16'h0206, 8'h00, 8'h52, 1'b0, 0);
    cpu_access(1'b0, 16'h0207, 8'h00, 8'h53, 1'b1, 1);

    repeat (3) @(negedge clock);
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
